// File: rtl/bp_cce_pkg.sv
// Shared CCE directory types: coherence state encoding, entry width helper and the LRU scan FSM states.
package bp_cce_pkg;

  localparam int bp_coh_bits       = 3;
  localparam int coh_shared_bit_lp = 0;

  // Bit 0 is the shared bit: S, F and O keep other copies alive; E and M are exclusive.
  typedef enum logic [bp_coh_bits-1:0] {
    e_COH_I = 3'b000,
    e_COH_S = 3'b001,
    e_COH_E = 3'b010,
    e_COH_F = 3'b011,
    e_COH_M = 3'b110,
    e_COH_O = 3'b111
  } bp_coh_states_e;

  typedef enum logic [1:0] {
    e_lru_idle = 2'd0,
    e_lru_scan = 2'd1,
    e_lru_done = 2'd2
  } bp_cce_lru_scan_state_e;

  // A directory entry is {state, tag} with the state in the upper bits.
  function automatic int dir_entry_width(input int tag_width);
    return bp_coh_bits + tag_width;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bp_cce_dir_row_slot_sel.sv
// Combinational mux picking one (slot, way) entry and its tag-set valid bit out of a directory row.
module bp_cce_dir_row_slot_sel
  import bp_cce_pkg::*;
#(
  parameter int assoc_p            = 8,
  parameter int tag_sets_per_row_p = 2,
  parameter int tag_width_p        = 10,
  localparam int entry_width_lp    = dir_entry_width(tag_width_p),
  localparam int num_entries_lp    = tag_sets_per_row_p * assoc_p,
  localparam int row_width_lp      = num_entries_lp * entry_width_lp,
  localparam int lg_assoc_lp       = safe_clog2(assoc_p),
  localparam int lg_tsp_lp         = safe_clog2(tag_sets_per_row_p),
  localparam int lg_entries_lp     = safe_clog2(num_entries_lp)
) (
  input  logic [row_width_lp-1:0]       row_i,
  input  logic [lg_tsp_lp-1:0]          slot_i,
  input  logic [lg_assoc_lp-1:0]        way_i,
  input  logic [tag_sets_per_row_p-1:0] tag_sets_v_i,
  output logic                          v_o,
  output logic [bp_coh_bits-1:0]        state_o,
  output logic [tag_width_p-1:0]        tag_o
);

  typedef struct packed {
    logic [bp_coh_bits-1:0] state;
    logic [tag_width_p-1:0] tag;
  } dir_entry_s;

  dir_entry_s [num_entries_lp-1:0] entries;
  logic [lg_entries_lp-1:0]        sel_idx;
  dir_entry_s                      sel_entry;

  assign entries = row_i;

  // Slot-major layout: entry index = slot*assoc + way.
  always_comb begin
    sel_idx = lg_entries_lp'(way_i);
    if (tag_sets_per_row_p > 1) begin
      sel_idx = sel_idx + lg_entries_lp'(slot_i) * lg_entries_lp'(assoc_p);
    end
  end

  assign sel_entry = entries[sel_idx];
  assign state_o   = sel_entry.state;
  assign tag_o     = sel_entry.tag;

  if (tag_sets_per_row_p == 1) begin : g_one_set
    assign v_o = tag_sets_v_i[0];
  end else begin : g_many_sets
    assign v_o = tag_sets_v_i[slot_i];
  end

endmodule

// File: rtl/bp_cce_dir_lru_scan.sv
// Sequential LRU extractor: accepts one lookup, scans a multi-beat directory row stream, returns a registered result.
// Handshakes: a lookup transfers on v_i & ready_o; a result transfers on v_o & yumi_i; row beats have no backpressure.
module bp_cce_dir_lru_scan
  import bp_cce_pkg::*;
#(
  parameter int num_lce_p          = 8,
  parameter int assoc_p            = 8,
  parameter int tag_sets_per_row_p = 2,
  parameter int rows_per_set_p     = 4,
  parameter int tag_width_p        = 10,
  localparam int entry_width_lp    = dir_entry_width(tag_width_p),
  localparam int row_width_p       = tag_sets_per_row_p * assoc_p * entry_width_lp,
  localparam int lg_lce_lp         = safe_clog2(num_lce_p),
  localparam int lg_assoc_lp       = safe_clog2(assoc_p),
  localparam int lg_rows_lp        = safe_clog2(rows_per_set_p),
  localparam int lg_tsp_lp         = safe_clog2(tag_sets_per_row_p),
  localparam int tsp_shift_lp      = $clog2(tag_sets_per_row_p),
  localparam int cnt_width_lp      = $clog2(rows_per_set_p + 1)
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          v_i,
  output logic                          ready_o,
  input  logic [lg_lce_lp-1:0]          lce_i,
  input  logic [lg_assoc_lp-1:0]        lru_way_i,
  input  logic                          row_v_i,
  input  logic [row_width_p-1:0]        row_i,
  input  logic [lg_rows_lp-1:0]         row_num_i,
  input  logic [tag_sets_per_row_p-1:0] row_tag_sets_v_i,
  output logic                          v_o,
  input  logic                          yumi_i,
  output logic                          lru_v_o,
  output logic                          lru_cached_o,
  output logic                          lru_cached_excl_o,
  output logic [tag_width_p-1:0]        lru_tag_o,
  output logic [bp_coh_bits-1:0]        lru_state_o,
  output bp_cce_lru_scan_state_e        scan_state_o
);

  bp_cce_lru_scan_state_e   state_r;
  logic [cnt_width_lp-1:0]  cnt_r, cnt_nxt;
  logic [lg_lce_lp-1:0]     lce_r;
  logic [lg_assoc_lp-1:0]   way_r;
  logic                     seen_r, cap_v_r;
  logic [bp_coh_bits-1:0]   cap_state_r;
  logic [tag_width_p-1:0]   cap_tag_r;

  logic [lg_rows_lp-1:0]    target_row;
  logic [lg_tsp_lp-1:0]     target_slot;
  logic                     sel_v;
  logic [bp_coh_bits-1:0]   sel_state;
  logic [tag_width_p-1:0]   sel_tag;
  logic                     row_hit, last_beat;
  logic                     nxt_seen, nxt_v, res_v;
  logic [bp_coh_bits-1:0]   nxt_state;
  logic [tag_width_p-1:0]   nxt_tag;

  assign scan_state_o = state_r;
  assign target_row   = lg_rows_lp'(lce_r >> tsp_shift_lp);

  if (tag_sets_per_row_p == 1) begin : g_one_slot
    assign target_slot = '0;
  end else begin : g_slot
    assign target_slot = lce_r[lg_tsp_lp-1:0];
  end

  bp_cce_dir_row_slot_sel #(
    .assoc_p           (assoc_p),
    .tag_sets_per_row_p(tag_sets_per_row_p),
    .tag_width_p       (tag_width_p)
  ) slot_sel (
    .row_i       (row_i),
    .slot_i      (target_slot),
    .way_i       (way_r),
    .tag_sets_v_i(row_tag_sets_v_i),
    .v_o         (sel_v),
    .state_o     (sel_state),
    .tag_o       (sel_tag)
  );

  assign row_hit   = (state_r == e_lru_scan) && row_v_i && (row_num_i == target_row);
  assign cnt_nxt   = cnt_r + cnt_width_lp'(1);
  assign last_beat = (cnt_nxt == cnt_width_lp'(rows_per_set_p));

  // Capture as it would stand after this beat, so the final beat feeds the result directly.
  always_comb begin
    nxt_seen  = seen_r;
    nxt_v     = cap_v_r;
    nxt_state = cap_state_r;
    nxt_tag   = cap_tag_r;
    if (row_hit) begin
      nxt_seen  = 1'b1;
      nxt_v     = sel_v;
      nxt_state = sel_state;
      nxt_tag   = sel_tag;
    end
    res_v = nxt_seen & nxt_v;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r           <= e_lru_idle;
      cnt_r             <= '0;
      lce_r             <= '0;
      way_r             <= '0;
      seen_r            <= 1'b0;
      cap_v_r           <= 1'b0;
      cap_state_r       <= '0;
      cap_tag_r         <= '0;
      ready_o           <= 1'b1;
      v_o               <= 1'b0;
      lru_v_o           <= 1'b0;
      lru_cached_o      <= 1'b0;
      lru_cached_excl_o <= 1'b0;
      lru_tag_o         <= '0;
      lru_state_o       <= '0;
    end else begin
      case (state_r)
        e_lru_idle: begin
          if (v_i) begin
            state_r     <= e_lru_scan;
            ready_o     <= 1'b0;
            cnt_r       <= '0;
            lce_r       <= lce_i;
            way_r       <= lru_way_i;
            seen_r      <= 1'b0;
            cap_v_r     <= 1'b0;
            cap_state_r <= '0;
            cap_tag_r   <= '0;
          end
        end
        e_lru_scan: begin
          if (row_v_i) begin
            cnt_r       <= cnt_nxt;
            seen_r      <= nxt_seen;
            cap_v_r     <= nxt_v;
            cap_state_r <= nxt_state;
            cap_tag_r   <= nxt_tag;
            if (last_beat) begin
              state_r           <= e_lru_done;
              v_o               <= 1'b1;
              lru_v_o           <= res_v;
              lru_tag_o         <= res_v ? nxt_tag : '0;
              lru_state_o       <= res_v ? nxt_state : '0;
              lru_cached_o      <= res_v && (nxt_state != '0);
              lru_cached_excl_o <= res_v && (nxt_state != '0) && !nxt_state[coh_shared_bit_lp];
            end
          end
        end
        e_lru_done: begin
          if (yumi_i) begin
            state_r           <= e_lru_idle;
            ready_o           <= 1'b1;
            v_o               <= 1'b0;
            lru_v_o           <= 1'b0;
            lru_cached_o      <= 1'b0;
            lru_cached_excl_o <= 1'b0;
            lru_tag_o         <= '0;
            lru_state_o       <= '0;
          end
        end
        default: state_r <= e_lru_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_cce_dir_lru_scan.sv
// Directed bench for the LRU scan: one instance with two tag sets per row, one with a single tag set per row.
module tb_bp_cce_dir_lru_scan;
  import bp_cce_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- instance A: tsp=2, rows=4 ----------------
  logic         a_v, a_ready, a_row_v, a_v_o, a_yumi;
  logic [2:0]   a_lce, a_way;
  logic [207:0] a_row;
  logic [1:0]   a_row_num, a_tsv;
  logic         a_lru_v, a_cached, a_excl;
  logic [9:0]   a_tag;
  logic [2:0]   a_state;
  bp_cce_lru_scan_state_e a_scan_state;

  bp_cce_dir_lru_scan #(
    .num_lce_p(8), .assoc_p(8), .tag_sets_per_row_p(2), .rows_per_set_p(4), .tag_width_p(10)
  ) dut_a (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(a_v), .ready_o(a_ready), .lce_i(a_lce),
    .lru_way_i(a_way), .row_v_i(a_row_v), .row_i(a_row), .row_num_i(a_row_num),
    .row_tag_sets_v_i(a_tsv), .v_o(a_v_o), .yumi_i(a_yumi), .lru_v_o(a_lru_v),
    .lru_cached_o(a_cached), .lru_cached_excl_o(a_excl), .lru_tag_o(a_tag),
    .lru_state_o(a_state), .scan_state_o(a_scan_state)
  );

  // ---------------- instance B: tsp=1, rows=8 ----------------
  logic         b_v, b_ready, b_row_v, b_v_o, b_yumi;
  logic [2:0]   b_lce, b_way, b_row_num;
  logic [103:0] b_row;
  logic [0:0]   b_tsv;
  logic         b_lru_v, b_cached, b_excl;
  logic [9:0]   b_tag;
  logic [2:0]   b_state;
  bp_cce_lru_scan_state_e b_scan_state;

  bp_cce_dir_lru_scan #(
    .num_lce_p(8), .assoc_p(8), .tag_sets_per_row_p(1), .rows_per_set_p(8), .tag_width_p(10)
  ) dut_b (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(b_v), .ready_o(b_ready), .lce_i(b_lce),
    .lru_way_i(b_way), .row_v_i(b_row_v), .row_i(b_row), .row_num_i(b_row_num),
    .row_tag_sets_v_i(b_tsv), .v_o(b_v_o), .yumi_i(b_yumi), .lru_v_o(b_lru_v),
    .lru_cached_o(b_cached), .lru_cached_excl_o(b_excl), .lru_tag_o(b_tag),
    .lru_state_o(b_state), .scan_state_o(b_scan_state)
  );

  // ---------------- row builders ----------------
  // Filler entries are O-state with a tag unique to (row, index), so a wrong pick is visible.
  function automatic logic [207:0] a_mk_row(input int r, input int slot, input int way,
                                            input logic [2:0] st, input logic [9:0] tg);
    logic [207:0] row;
    row = '0;
    for (int i = 0; i < 16; i++) row[i*13 +: 13] = {3'b111, 10'(32'h300 + r*16 + i)};
    if (slot >= 0) row[(slot*8 + way)*13 +: 13] = {st, tg};
    return row;
  endfunction

  function automatic logic [103:0] b_mk_row(input int r, input int way,
                                            input logic [2:0] st, input logic [9:0] tg);
    logic [103:0] row;
    row = '0;
    for (int i = 0; i < 8; i++) row[i*13 +: 13] = {3'b111, 10'(32'h200 + r*8 + i)};
    if (way >= 0) row[way*13 +: 13] = {st, tg};
    return row;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic a_start(input logic [2:0] lce, input logic [2:0] way);
    a_v = 1'b1; a_lce = lce; a_way = way;
    tick();
    a_v = 1'b0;
  endtask

  task automatic a_beat(input logic [1:0] num, input logic [207:0] row, input logic [1:0] tsv);
    a_row_v = 1'b1; a_row_num = num; a_row = row; a_tsv = tsv;
    tick();
    a_row_v = 1'b0;
  endtask

  task automatic b_beat(input logic [2:0] num, input logic [103:0] row);
    b_row_v = 1'b1; b_row_num = num; b_row = row; b_tsv = 1'b1;
    tick();
    b_row_v = 1'b0;
  endtask

  task automatic a_expect(input string tag, input logic lv, input logic c, input logic x,
                          input logic [9:0] tg, input logic [2:0] st);
    check({tag, "_v_o"},    a_v_o,    1);
    check({tag, "_lru_v"},  a_lru_v,  lv);
    check({tag, "_cached"}, a_cached, c);
    check({tag, "_excl"},   a_excl,   x);
    check({tag, "_tag"},    a_tag,    tg);
    check({tag, "_state"},  a_state,  st);
  endtask

  task automatic a_consume(input string tag);
    check({tag, "_ready_before_yumi"}, a_ready, 0);
    a_yumi = 1'b1;
    tick();
    a_yumi = 1'b0;
    check({tag, "_ready_after_yumi"}, a_ready, 1);
    check({tag, "_v_o_after_yumi"},   a_v_o,   0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    a_v = 0; a_lce = 0; a_way = 0; a_row_v = 0; a_row = '0; a_row_num = 0; a_tsv = 0; a_yumi = 0;
    b_v = 0; b_lce = 0; b_way = 0; b_row_v = 0; b_row = '0; b_row_num = 0; b_tsv = 0; b_yumi = 0;

    // 1. Reset, then reset again mid-scan.
    tick(3);
    check("rst_a_ready", a_ready, 1);
    check("rst_a_v_o",   a_v_o,   0);
    check("rst_b_ready", b_ready, 1);
    check("rst_b_v_o",   b_v_o,   0);
    reset_n = 1'b1;
    tick();
    a_start(3'd1, 3'd0);
    check("t1_scan_ready", a_ready, 0);
    check("t1_scan_state", a_scan_state, e_lru_scan);
    a_beat(2'd0, a_mk_row(0, 0, 0, e_COH_M, 10'h111), 2'b11);
    a_beat(2'd1, a_mk_row(1, -1, 0, e_COH_I, 10'h0), 2'b11);
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick();
    check("t1_ready", a_ready, 1);
    check("t1_v_o",   a_v_o,   0);
    check("t1_lru_v", a_lru_v, 0);
    check("t1_tag",   a_tag,   0);
    check("t1_state", a_state, 0);
    check("t1_cached", a_cached, 0);
    check("t1_excl",  a_excl,  0);
    // Beats while idle must not complete anything.
    a_beat(2'd2, a_mk_row(2, -1, 0, e_COH_I, 10'h0), 2'b11);
    a_beat(2'd3, a_mk_row(3, -1, 0, e_COH_I, 10'h0), 2'b11);
    tick();
    check("t1_idle_beats_v_o",   a_v_o,   0);
    check("t1_idle_beats_ready", a_ready, 1);

    // 2. lce=5 (row 2, slot 1), way 3 = {M, 0x2A5}; in-order back-to-back beats.
    a_start(3'd5, 3'd3);
    a_beat(2'd0, a_mk_row(0, -1, 0, e_COH_I, 10'h0), 2'b11);
    a_beat(2'd1, a_mk_row(1, -1, 0, e_COH_I, 10'h0), 2'b11);
    a_beat(2'd2, a_mk_row(2, 1, 3, e_COH_M, 10'h2A5), 2'b11);
    check("t2_v_o_before_last", a_v_o, 0);
    a_beat(2'd3, a_mk_row(3, -1, 0, e_COH_I, 10'h0), 2'b11);
    a_expect("t2", 1, 1, 1, 10'h2A5, e_COH_M);
    a_consume("t2");

    // 3. lce=4 (row 2, slot 0), way 0 = {S, 0x011}; beats 3,2,0,1 with gaps.
    a_start(3'd4, 3'd0);
    a_beat(2'd3, a_mk_row(3, -1, 0, e_COH_I, 10'h0), 2'b11);
    tick(2);
    a_beat(2'd2, a_mk_row(2, 0, 0, e_COH_S, 10'h011), 2'b11);
    tick();
    a_beat(2'd0, a_mk_row(0, -1, 0, e_COH_I, 10'h0), 2'b11);
    tick(3);
    check("t3_v_o_before_last", a_v_o, 0);
    a_beat(2'd1, a_mk_row(1, -1, 0, e_COH_I, 10'h0), 2'b11);
    a_expect("t3", 1, 1, 0, 10'h011, e_COH_S);
    a_consume("t3");

    // 4. lce=6 (row 3, slot 0) with its tag set marked invalid: everything masked.
    a_start(3'd6, 3'd5);
    a_beat(2'd0, a_mk_row(0, -1, 0, e_COH_I, 10'h0), 2'b11);
    a_beat(2'd3, a_mk_row(3, 0, 5, e_COH_M, 10'h1FF), 2'b10);
    a_beat(2'd1, a_mk_row(1, -1, 0, e_COH_I, 10'h0), 2'b11);
    a_beat(2'd2, a_mk_row(2, -1, 0, e_COH_I, 10'h0), 2'b11);
    a_expect("t4", 0, 0, 0, 10'h000, 3'b000);
    a_consume("t4");

    // 5. Hold result without yumi while beats and requests keep arriving.
    a_start(3'd2, 3'd7);
    a_beat(2'd1, a_mk_row(1, 0, 7, e_COH_E, 10'h0F0), 2'b11);
    a_beat(2'd0, a_mk_row(0, -1, 0, e_COH_I, 10'h0), 2'b11);
    a_beat(2'd2, a_mk_row(2, -1, 0, e_COH_I, 10'h0), 2'b11);
    a_beat(2'd3, a_mk_row(3, -1, 0, e_COH_I, 10'h0), 2'b11);
    a_expect("t5a", 1, 1, 1, 10'h0F0, e_COH_E);
    for (int i = 0; i < 5; i++) begin
      a_v = 1'b1; a_lce = 3'd0; a_way = 3'd1;
      a_row_v = 1'b1; a_row_num = 2'd1; a_row = a_mk_row(1, 0, 7, e_COH_S, 10'h123); a_tsv = 2'b01;
      tick();
      check("t5_hold_v_o",   a_v_o,   1);
      check("t5_hold_tag",   a_tag,   10'h0F0);
      check("t5_hold_ready", a_ready, 0);
    end
    a_v = 1'b0; a_row_v = 1'b0;
    a_consume("t5a");
    // New lookup right away: lce=3 (row 1, slot 1), way 1; second row-1 beat wins.
    a_start(3'd3, 3'd1);
    check("t5b_ready_after_accept", a_ready, 0);
    a_beat(2'd1, a_mk_row(1, 1, 1, e_COH_F, 10'h0AA), 2'b11);
    a_beat(2'd0, a_mk_row(0, -1, 0, e_COH_I, 10'h0), 2'b11);
    a_beat(2'd1, a_mk_row(1, 1, 1, e_COH_E, 10'h155), 2'b11);
    a_beat(2'd2, a_mk_row(2, -1, 0, e_COH_I, 10'h0), 2'b11);
    a_expect("t5b", 1, 1, 1, 10'h155, e_COH_E);
    a_consume("t5b");

    // 6. Single tag set per row: lce=7 -> row 7, way 2 = {E, 0x3FF}.
    b_v = 1'b1; b_lce = 3'd7; b_way = 3'd2;
    tick();
    b_v = 1'b0;
    for (int r = 0; r < 7; r++) b_beat(3'(r), b_mk_row(r, -1, e_COH_I, 10'h0));
    check("t6_v_o_before_last", b_v_o, 0);
    b_beat(3'd7, b_mk_row(7, 2, e_COH_E, 10'h3FF));
    check("t6_v_o",    b_v_o,    1);
    check("t6_lru_v",  b_lru_v,  1);
    check("t6_cached", b_cached, 1);
    check("t6_excl",   b_excl,   1);
    check("t6_tag",    b_tag,    10'h3FF);
    check("t6_state",  b_state,  e_COH_E);
    b_yumi = 1'b1;
    tick();
    b_yumi = 1'b0;
    check("t6_ready_after_yumi", b_ready, 1);

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
